uart_tx_param: RTL
==================

// Module: uart_tx_param
// PURPOSE
//  Parametrised UART transmitter; next generation of the fixed 8N1 tx path.
//  Serialises one DATA_BITS word per frame: start, data LSB-first, optional parity, 1 or 2 stops.
//  Uses a valid/ready handshake in place of free-running enable sampling.
//  Sits between the system-side byte source and the tx pin; drives the line directly.
// PARAMETERS
//  DATA_BITS     8     data bits per frame, legal 5..9
//  CLKS_PER_BIT  5208  clk cycles per bit period, legal >=2 (50 MHz / 9600 baud)
//  PARITY_EN     0     1 = append parity bit after data
//  PARITY_ODD    0     0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
//  STOP_BITS     1     stop bits per frame, legal 1 or 2
// PORTS
//  clk         in   1          system clock, all logic on rising edge
//  tx_rst_n    in   1          synchronous active-low reset
//  tx_en       in   1          transmitter enable; gates acceptance of new frames
//  data_in     in   DATA_BITS  word to send, sampled on accept
//  data_valid  in   1          source has a word on data_in
//  ready       out  1          block can accept a word this cycle
//  busy        out  1          frame in progress (START..STOP)
//  done        out  1          1-cycle pulse when final stop bit period ends
//  tx_bit      out  1          serial line, idle high, registered
// BEHAVIOUR
//  Reset (tx_rst_n=0 at clk edge): state=IDLE, tx_bit=1, busy=0, done=0, counters=0.
//  Reset mid-frame: frame is aborted, tx_bit=1 the following cycle, no done pulse.
//  ready = (state==IDLE) & tx_en, combinational from registered state.
//  Accept = data_valid & ready; on accept latch data_in and parity, go to START.
//  Latency: tx_bit falls on the cycle after accept (registered output).
//  FSM: IDLE -> START -> DATA -> [PARITY if PARITY_EN] -> STOP -> IDLE.
//  Each bit is held exactly CLKS_PER_BIT cycles. Baud counter width is $clog2(CLKS_PER_BIT).
//   The counter runs 0..CLKS_PER_BIT-1; the bit advances when it hits terminal count.
//  DATA: bit index 0..DATA_BITS-1, LSB first; index width $clog2(DATA_BITS).
//  PARITY: even = ^data, odd = ~^data, computed from the latched word.
//  STOP: tx_bit=1 for STOP_BITS*CLKS_PER_BIT cycles.
//  Exit from STOP: done=1 for one cycle and state=IDLE in the same cycle.
//   ready may therefore assert in the done cycle.
//  Back-to-back frames: accept in the done cycle gives exactly 1 idle-high cycle between frames.
//  busy=1 in START/DATA/PARITY/STOP, 0 in IDLE.
//  tx_en deasserted mid-frame: the current frame completes normally and no new accept occurs.
//   Deasserting tx_en never corrupts the line.
//  data_valid while busy is ignored. data_in changes after accept have no effect.
//  data_valid and tx_en rising together in IDLE: accepted that same cycle.
//  Frame length = (1+DATA_BITS+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
// STRUCTURE
//  uart_pkg.vh: state encodings (IDLE/START/DATA/PARITY/STOP) and parity-mode localparams.
//   Shared with the rx side.
//  Sub-module uart_baud_gen: CLKS_PER_BIT counter with clear input and terminal-count tick.
//   Reusable by rx.
//  Top holds the FSM, shift register, bit index and output register.
// TESTING
//  8N1, CLKS_PER_BIT=4, send 0xA5:
//   -> tx_bit = 0, then 1,0,1,0,0,1,0,1, then 1; each bit 4 cycles.
//   -> done pulses at cycle 40 after accept.
//  DATA_BITS=7, even parity, send 7'h03: parity bit 0. Same word with odd parity: parity bit 1.
//  STOP_BITS=2: stop high for 8 cycles. Hold data_valid=1 for 2 words:
//   -> exactly 1 idle cycle between frames; ready high only in IDLE.
//  Assert tx_rst_n=0 during DATA bit 3:
//   -> next cycle tx_bit=1, busy=0, no done pulse.
//   -> a word offered after reset is sent correctly.
//  Drop tx_en mid-frame: frame completes with done pulse; ready stays 0.
//   Raise tx_en: the pending data_valid is accepted.
//  data_valid pulsed while busy, with data_in toggling: no effect on tx_bit; word not sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-mode constants and a parity helper.
// Used by both the tx and rx paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int MAX_DATA_BITS = 9;

  // Zero-extended words keep the same XOR, so one width serves every DATA_BITS.
  function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] word,
                                     input logic                     mode);
    return (^word) ^ mode;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// Held at zero while clear is high, so the first period after clear is full length.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == TERMINAL);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_BITS LSB-first, optional parity, 1-2 stops.
// Valid/ready input handshake; tx_bit is driven straight from a flop.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 tx_rst_n,
  input  logic                 tx_en,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic                 tx_bit
);

  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
  localparam logic          PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  uart_state_t          state, state_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 par_bit, par_next;
  logic [IW-1:0]        bit_idx, idx_next;
  logic                 tx_next, done_next;
  logic                 tick, accept;

  assign ready  = (state == ST_IDLE) && tx_en;
  assign busy   = (state != ST_IDLE);
  assign accept = ready && data_valid;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(tx_rst_n),
    .clear(state == ST_IDLE),
    .tick (tick)
  );

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    shift_next = shift;
    par_next   = par_bit;
    idx_next   = bit_idx;
    tx_next    = tx_bit;
    done_next  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_START;
          shift_next = data_in;
          par_next   = parity_of(MAX_DATA_BITS'(data_in), PAR_MODE);
          idx_next   = '0;
          tx_next    = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_next = ST_DATA;
          tx_next    = shift[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx == LAST_DATA) begin
            idx_next = '0;
            if (PARITY_EN != 0) begin
              state_next = ST_PARITY;
              tx_next    = par_bit;
            end else begin
              state_next = ST_STOP;
              tx_next    = 1'b1;
            end
          end else begin
            idx_next   = bit_idx + 1'b1;
            shift_next = shift >> 1;
            tx_next    = shift_next[0];
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_next = ST_STOP;
          idx_next   = '0;
          tx_next    = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_idx == LAST_STOP) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            idx_next = bit_idx + 1'b1;
          end
          tx_next = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  // Reset returns the line to idle-high at once and suppresses any pending done.
  always_ff @(posedge clk) begin
    if (!tx_rst_n) begin
      state   <= ST_IDLE;
      shift   <= '0;
      par_bit <= 1'b0;
      bit_idx <= '0;
      tx_bit  <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      shift   <= shift_next;
      par_bit <= par_next;
      bit_idx <= idx_next;
      tx_bit  <= tx_next;
      done    <= done_next;
    end
  end

endmodule
